// File: rtl/ehl_ahb_pkg.sv
// Shared AHB-Lite encodings and small helpers for the ehl_ahb matrix blocks.
package ehl_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } dflt_state_e;

    // NONSEQ and SEQ both have bit 1 set; IDLE/BUSY never start a data phase.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/ehl_ahb_matrix_in_if.sv
// Bus bundle of one matrix input stage: master-facing side and per-slave fan-out side.
interface ehl_ahb_matrix_in_if #(
    parameter int SNUM = 4
);
    logic [31:0]        m_haddr;
    logic [1:0]         m_htrans;
    logic               m_hwrite;
    logic [2:0]         m_hsize;
    logic [2:0]         m_hburst;
    logic [3:0]         m_hprot;
    logic [31:0]        m_hwdata;
    logic [31:0]        m_hrdata;
    logic               m_hready;
    logic [1:0]         m_hresp;

    logic [SNUM*32-1:0] o_haddr;
    logic [SNUM*2-1:0]  o_htrans;
    logic [SNUM-1:0]    o_hwrite;
    logic [SNUM*3-1:0]  o_hsize;
    logic [SNUM*3-1:0]  o_hburst;
    logic [SNUM*4-1:0]  o_hprot;
    logic [SNUM*32-1:0] o_hwdata;
    logic [SNUM*32-1:0] i_hrdata;
    logic [SNUM-1:0]    i_hready;
    logic [SNUM*2-1:0]  i_hresp;

    // The input stage is the slave of its upstream master.
    modport slave (
        input  m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hprot, m_hwdata,
        output m_hrdata, m_hready, m_hresp
    );

    // The input stage acts as a master towards the per-slave output stages.
    modport master (
        output o_haddr, o_htrans, o_hwrite, o_hsize, o_hburst, o_hprot, o_hwdata,
        input  i_hrdata, i_hready, i_hresp
    );

endinterface

// File: rtl/ehl_ahb_default_slave.sv
// Default slave: answers every unmapped transfer with a two-cycle ERROR response.
module ehl_ahb_default_slave
    import ehl_ahb_pkg::*;
(
    input  logic       hclk,
    input  logic       hresetn,
    input  logic       accept_unmapped,
    output logic       hready,
    output logic [1:0] hresp,
    output logic       err_pulse
);

    dflt_state_e state_q, state_d;

    // State register.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= DS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and error pulse; kept apart from the response so hready never depends on accept.
    always_comb begin
        state_d   = state_q;
        err_pulse = 1'b0;
        case (state_q)
            DS_IDLE: begin
                if (accept_unmapped) begin
                    state_d   = DS_ERR1;
                    err_pulse = 1'b1;
                end else begin
                    state_d   = DS_IDLE;
                end
            end
            DS_ERR1: begin
                state_d = DS_ERR2;
            end
            DS_ERR2: begin
                if (accept_unmapped) begin
                    state_d   = DS_ERR1;
                    err_pulse = 1'b1;
                end else begin
                    state_d   = DS_IDLE;
                end
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase
    end

    // Response outputs, a pure function of state.
    always_comb begin
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        case (state_q)
            DS_ERR1: begin
                hready = 1'b0;
                hresp  = HRESP_ERROR;
            end
            DS_ERR2: begin
                hready = 1'b1;
                hresp  = HRESP_ERROR;
            end
            default: begin
                hready = 1'b1;
                hresp  = HRESP_OKAY;
            end
        endcase
    end

endmodule

// File: rtl/ehl_ahb_matrix_in.sv
// Per-master AHB matrix input stage: address decode and broadcast, data-phase
// owner tracking, response mux, default slave and saturating decode-error count.
module ehl_ahb_matrix_in
    import ehl_ahb_pkg::*;
#(
    parameter int                 SNUM     = 4,
    parameter logic [SNUM*32-1:0] SLV_BASE = {SNUM{32'h0000_0000}},
    parameter logic [SNUM*32-1:0] SLV_MASK = {SNUM{32'hF000_0000}}
) (
    input  logic                hclk,
    input  logic                hresetn,
    ehl_ahb_matrix_in_if.slave  mst_if,
    ehl_ahb_matrix_in_if.master slv_if,
    input  logic                err_clr,
    output logic [7:0]          err_cnt
);

    logic [SNUM-1:0] hit_s;
    logic [SNUM-1:0] sel_s;
    logic            found_s;
    logic            unmapped_s;
    logic            accept_s;
    logic            accept_unmapped_s;
    logic [SNUM-1:0] dsel_q, dsel_d;
    logic            dflt_q, dflt_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            dflt_hready_s;
    logic [1:0]      dflt_hresp_s;
    logic            err_pulse_s;
    logic [31:0]     rsp_hrdata_s;
    logic            rsp_hready_s;
    logic [1:0]      rsp_hresp_s;

    for (genvar s = 0; s < SNUM; s++) begin : g_slot
        assign hit_s[s] = ((mst_if.m_haddr & SLV_MASK[s*32 +: 32]) == SLV_BASE[s*32 +: 32]);

        assign slv_if.o_haddr[s*32 +: 32] = mst_if.m_haddr;
        assign slv_if.o_htrans[s*2 +: 2]  = sel_s[s] ? mst_if.m_htrans : HTRANS_IDLE;
        assign slv_if.o_hwrite[s]         = mst_if.m_hwrite;
        assign slv_if.o_hsize[s*3 +: 3]   = mst_if.m_hsize;
        assign slv_if.o_hburst[s*3 +: 3]  = mst_if.m_hburst;
        assign slv_if.o_hprot[s*4 +: 4]   = mst_if.m_hprot;
        assign slv_if.o_hwdata[s*32 +: 32] = mst_if.m_hwdata;
    end

    // Priority select: lowest-index hit wins when regions overlap.
    always_comb begin
        sel_s   = {SNUM{1'b0}};
        found_s = 1'b0;
        for (int s = 0; s < SNUM; s++) begin
            if (hit_s[s] && !found_s) begin
                sel_s[s] = 1'b1;
                found_s  = 1'b1;
            end else begin
                sel_s[s] = 1'b0;
            end
        end
    end

    assign unmapped_s        = ~|hit_s;
    assign accept_s          = rsp_hready_s & htrans_active(mst_if.m_htrans);
    assign accept_unmapped_s = accept_s & unmapped_s;

    ehl_ahb_default_slave u_dflt (
        .hclk            (hclk),
        .hresetn         (hresetn),
        .accept_unmapped (accept_unmapped_s),
        .hready          (dflt_hready_s),
        .hresp           (dflt_hresp_s),
        .err_pulse       (err_pulse_s)
    );

    // Data-phase owner only moves when the current data phase completes.
    always_comb begin
        dsel_d = dsel_q;
        dflt_d = dflt_q;
        if (rsp_hready_s) begin
            dsel_d = accept_s ? sel_s : {SNUM{1'b0}};
            dflt_d = accept_unmapped_s;
        end else begin
            dsel_d = dsel_q;
            dflt_d = dflt_q;
        end
    end

    // Response mux back to the master; no owner means an idle OKAY.
    always_comb begin
        rsp_hrdata_s = 32'h0000_0000;
        rsp_hready_s = 1'b1;
        rsp_hresp_s  = HRESP_OKAY;
        if (dflt_q) begin
            rsp_hready_s = dflt_hready_s;
            rsp_hresp_s  = dflt_hresp_s;
        end else begin
            for (int s = 0; s < SNUM; s++) begin
                if (dsel_q[s]) begin
                    rsp_hrdata_s = slv_if.i_hrdata[s*32 +: 32];
                    rsp_hready_s = slv_if.i_hready[s];
                    rsp_hresp_s  = slv_if.i_hresp[s*2 +: 2];
                end else begin
                    rsp_hrdata_s = rsp_hrdata_s;
                end
            end
        end
    end

    // Saturating error counter; clear beats a same-cycle increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = 8'h00;
        end else if (err_pulse_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'h01;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Sequential state of the stage.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dsel_q    <= {SNUM{1'b0}};
            dflt_q    <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            dsel_q    <= dsel_d;
            dflt_q    <= dflt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign mst_if.m_hrdata = rsp_hrdata_s;
    assign mst_if.m_hready = rsp_hready_s;
    assign mst_if.m_hresp  = rsp_hresp_s;
    assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_ehl_ahb_matrix_in.sv
// Directed bench for ehl_ahb_matrix_in with two slaves at 0x0000_0000 and 0x1000_0000.
module tb_ehl_ahb_matrix_in;

    localparam int SNUM = 2;
    localparam logic [31:0] RDATA0 = 32'h1111_0000;
    localparam logic [31:0] RDATA1 = 32'hCAFE_F00D;

    logic       hclk;
    logic       hresetn;
    logic       err_clr;
    logic [7:0] err_cnt;

    int checks;
    int errors;

    ehl_ahb_matrix_in_if #(.SNUM(SNUM)) bus ();

    ehl_ahb_matrix_in #(
        .SNUM     (SNUM),
        .SLV_BASE ({32'h1000_0000, 32'h0000_0000}),
        .SLV_MASK ({32'hF000_0000, 32'hF000_0000})
    ) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .mst_if  (bus),
        .slv_if  (bus),
        .err_clr (err_clr),
        .err_cnt (err_cnt)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic [1:0]  ihready;
        logic [3:0]  ihresp;
        logic [3:0]  exp_otrans;
        logic        exp_ready;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] addr, input logic [1:0] trans,
                         input logic [1:0] ihr, input logic [3:0] ihresp);
        bus.m_haddr  = addr;
        bus.m_htrans = trans;
        bus.i_hready = ihr;
        bus.i_hresp  = ihresp;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        hresetn = 1'b0;
        err_clr = 1'b0;
        bus.m_hwrite = 1'b0;
        bus.m_hsize  = 3'b010;
        bus.m_hburst = 3'b000;
        bus.m_hprot  = 4'b0011;
        bus.m_hwdata = 32'h5A5A_0001;
        bus.i_hrdata = {RDATA1, RDATA0};
        drive(32'h0000_0000, 2'b00, 2'b11, 4'h0);

        //                 haddr         trn    ihrdy  ihresp otrans   rdy   resp   rdata         cnt
        vecs[0]  = '{32'h1000_0040, 2'b10, 2'b11, 4'h0, 4'b1000, 1'b1, 2'b00, 32'h0,        8'd0};
        vecs[1]  = '{32'h0000_0000, 2'b00, 2'b11, 4'h0, 4'b0000, 1'b1, 2'b00, RDATA1,       8'd0};
        vecs[2]  = '{32'h0000_0010, 2'b10, 2'b11, 4'h0, 4'b0010, 1'b1, 2'b00, 32'h0,        8'd0};
        vecs[3]  = '{32'h0000_0020, 2'b11, 2'b10, 4'h0, 4'b0011, 1'b0, 2'b00, RDATA0,       8'd0};
        vecs[4]  = '{32'h0000_0020, 2'b11, 2'b10, 4'h0, 4'b0011, 1'b0, 2'b00, RDATA0,       8'd0};
        vecs[5]  = '{32'h0000_0020, 2'b11, 2'b10, 4'h0, 4'b0011, 1'b0, 2'b00, RDATA0,       8'd0};
        vecs[6]  = '{32'h0000_0020, 2'b11, 2'b11, 4'h0, 4'b0011, 1'b1, 2'b00, RDATA0,       8'd0};
        vecs[7]  = '{32'h4000_0000, 2'b10, 2'b11, 4'h0, 4'b0000, 1'b1, 2'b00, RDATA0,       8'd0};
        vecs[8]  = '{32'h0000_0000, 2'b00, 2'b11, 4'h0, 4'b0000, 1'b0, 2'b01, 32'h0,        8'd1};
        vecs[9]  = '{32'h4000_0004, 2'b10, 2'b11, 4'h0, 4'b0000, 1'b1, 2'b01, 32'h0,        8'd1};
        vecs[10] = '{32'h4000_0008, 2'b10, 2'b11, 4'h0, 4'b0000, 1'b0, 2'b01, 32'h0,        8'd2};
        vecs[11] = '{32'h1000_0000, 2'b10, 2'b11, 4'h0, 4'b1000, 1'b1, 2'b01, 32'h0,        8'd2};
        vecs[12] = '{32'h4000_0000, 2'b00, 2'b11, 4'h4, 4'b0000, 1'b1, 2'b01, RDATA1,       8'd2};
        vecs[13] = '{32'h4000_0000, 2'b01, 2'b11, 4'h0, 4'b0000, 1'b1, 2'b00, 32'h0,        8'd2};
        vecs[14] = '{32'h0000_0000, 2'b00, 2'b11, 4'h0, 4'b0000, 1'b1, 2'b00, 32'h0,        8'd2};

        repeat (2) @(negedge hclk);
        #1;
        check("reset_hready", {63'd0, bus.m_hready}, 64'd1);
        check("reset_hresp",  {62'd0, bus.m_hresp},  64'd0);
        check("reset_hrdata", {32'd0, bus.m_hrdata}, 64'd0);
        check("reset_errcnt", {56'd0, err_cnt},      64'd0);
        hresetn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge hclk);
            drive(vecs[i].haddr, vecs[i].htrans, vecs[i].ihready, vecs[i].ihresp);
            #1;
            check($sformatf("v%0d_otrans", i), {60'd0, bus.o_htrans}, {60'd0, vecs[i].exp_otrans});
            check($sformatf("v%0d_haddr", i), bus.o_haddr, {vecs[i].haddr, vecs[i].haddr});
            check($sformatf("v%0d_hready", i), {63'd0, bus.m_hready}, {63'd0, vecs[i].exp_ready});
            check($sformatf("v%0d_hresp", i), {62'd0, bus.m_hresp}, {62'd0, vecs[i].exp_resp});
            check($sformatf("v%0d_hrdata", i), {32'd0, bus.m_hrdata}, {32'd0, vecs[i].exp_rdata});
            check($sformatf("v%0d_errcnt", i), {56'd0, err_cnt}, {56'd0, vecs[i].exp_cnt});
        end

        // Reset arriving while the default slave sits in ERR1.
        @(negedge hclk);
        drive(32'h4000_0000, 2'b10, 2'b11, 4'h0);
        @(negedge hclk);
        drive(32'h0000_0000, 2'b00, 2'b11, 4'h0);
        #1;
        check("err1_before_reset_hready", {63'd0, bus.m_hready}, 64'd0);
        check("err1_before_reset_errcnt", {56'd0, err_cnt}, 64'd3);
        hresetn = 1'b0;
        #1;
        check("async_reset_hready", {63'd0, bus.m_hready}, 64'd1);
        check("async_reset_hresp",  {62'd0, bus.m_hresp},  64'd0);
        check("async_reset_errcnt", {56'd0, err_cnt},      64'd0);
        @(negedge hclk);
        #1;
        check("reset_next_hready", {63'd0, bus.m_hready}, 64'd1);
        check("reset_next_hresp",  {62'd0, bus.m_hresp},  64'd0);
        check("reset_next_otrans", {60'd0, bus.o_htrans}, 64'd0);
        hresetn = 1'b1;

        // Continuous unmapped traffic: an error starts every second cycle, counter saturates, then clear wins.
        begin
            logic [7:0] exp_cnt;
            exp_cnt = 8'h00;
            for (int k = 0; k < 524; k++) begin
                @(negedge hclk);
                drive(32'h4000_0000, 2'b10, 2'b11, 4'h0);
                err_clr = (k == 520) ? 1'b1 : 1'b0;
                #1;
                check($sformatf("sat_k%0d_errcnt", k), {56'd0, err_cnt}, {56'd0, exp_cnt});
                if (err_clr) begin
                    exp_cnt = 8'h00;
                end else if ((k % 2 == 0) && (exp_cnt != 8'hFF)) begin
                    exp_cnt = exp_cnt + 8'h01;
                end
            end
            @(negedge hclk);
            err_clr = 1'b0;
            drive(32'h0000_0000, 2'b00, 2'b11, 4'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
